// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address,
// buffers returned words in a 2-entry FIFO and hands {PC, PC+4, instruction}
// to decode over a valid/ready handshake. Redirect reloads the PC and flushes.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        OutReady,
  output logic        OutValid,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  output logic [31:0] FetchCount
);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_tail;
  logic [31:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];

  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_count_next;
  logic [31:0] w_target;
  logic        w_unused;

  // Target is word aligned; the low two bits of the request are dropped.
  assign w_target = {RedirectTarget[31:2], 2'b00};
  assign w_unused = ^RedirectTarget[1:0];

  assign OutValid = (r_count != 2'd0);
  assign w_pop    = OutValid & OutReady;
  // A full buffer can still accept a word when the head leaves this cycle.
  assign w_push   = ~Redirect & ((r_count != 2'd2) | w_pop);

  // Occupancy update: +1 on push, -1 on pop, unchanged on both or neither.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Control state: PC, FIFO pointers/occupancy and the transfer counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc          <= RESET_PC;
      r_count       <= 2'd0;
      r_head        <= 1'b0;
      r_tail        <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      // A same-cycle pop still counts even when the redirect flushes the buffer.
      if (w_pop) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (Redirect) begin
        r_pc    <= w_target;
        r_count <= 2'd0;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
      end else begin
        if (w_push) begin
          r_pc   <= r_pc + 32'd4;
          r_tail <= ~r_tail;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        r_count <= w_count_next;
      end
    end
  end

  // Buffer storage: written at the tail on push, contents otherwise held.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_buf_pc[r_tail]    <= r_pc;
      r_buf_instr[r_tail] <= Instruction;
    end
  end

  // Output drive: head entry when valid, zeros when the buffer is empty.
  always_comb begin
    OutPC          = 32'd0;
    OutInstruction = 32'd0;
    OutPCPlus4     = 32'd0;
    if (OutValid) begin
      OutPC          = r_buf_pc[r_head];
      OutInstruction = r_buf_instr[r_head];
      OutPCPlus4     = r_buf_pc[r_head] + 32'd4;
    end
  end

  assign Address    = r_pc;
  assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirect,
// full-buffer push/pop, asynchronous reset and PC wrap.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address, Address2;
  logic [31:0] Instruction, Instruction2;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        OutReady;
  logic        OutValid, OutValid2;
  logic [31:0] OutInstruction, OutInstruction2;
  logic [31:0] OutPC, OutPC2;
  logic [31:0] OutPCPlus4, OutPCPlus4_2;
  logic [31:0] FetchCount, FetchCount2;
  logic        Redirect2 = 1'b0;
  logic [31:0] RedirectTarget2 = 32'd0;
  logic        OutReady2 = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  // Memory model: word i holds i*3.
  assign Instruction  = (Address >> 2) * 32'd3;
  assign Instruction2 = (Address2 >> 2) * 32'd3;

  instruction_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Instruction(Instruction),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .OutReady(OutReady),
    .OutValid(OutValid), .OutInstruction(OutInstruction), .OutPC(OutPC),
    .OutPCPlus4(OutPCPlus4), .FetchCount(FetchCount)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .Address(Address2), .Instruction(Instruction2),
    .Redirect(Redirect2), .RedirectTarget(RedirectTarget2), .OutReady(OutReady2),
    .OutValid(OutValid2), .OutInstruction(OutInstruction2), .OutPC(OutPC2),
    .OutPCPlus4(OutPCPlus4_2), .FetchCount(FetchCount2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge, reset released: cycle 0.
  task automatic do_reset();
    Reset = 1'b1;
    Redirect = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n_pops;
    Reset = 1'b0;
    Redirect = 1'b0;
    RedirectTarget = 32'd0;
    OutReady = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #1 Reset = 1'b1;
    #2;
    chk("rst_addr", Address, 32'h0);
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_outpc", OutPC, 32'h0);
    chk("rst_fcount", FetchCount, 32'h0);
    chk("rst_addr_wrap", Address2, 32'hFFFF_FFFC);

    // Streaming with OutReady held high.
    do_reset();
    OutReady = 1'b1;
    chk("str_c0_addr", Address, 32'h0);
    chk("str_c0_valid", {31'd0, OutValid}, 32'd0);
    chk("wrap_c0_addr", Address2, 32'hFFFF_FFFC);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("str_valid", {31'd0, OutValid}, 32'd1);
      chk("str_pc", OutPC, 32'(4 * (k - 1)));
      chk("str_instr", OutInstruction, 32'(3 * (k - 1)));
      chk("str_pc4", OutPCPlus4, 32'(4 * k));
      chk("str_fcount", FetchCount, 32'(k - 1));
      if (k == 1) begin
        chk("wrap_pc0", OutPC2, 32'hFFFF_FFFC);
        chk("wrap_pc4_0", OutPCPlus4_2, 32'h0);
        chk("wrap_addr1", Address2, 32'h0);
      end
      if (k == 2) begin
        chk("wrap_pc1", OutPC2, 32'h0);
        chk("wrap_pc4_1", OutPCPlus4_2, 32'h4);
      end
    end
    step();
    chk("str_fcount10", FetchCount, 32'd10);
    chk("str_pc11", OutPC, 32'd40);

    // Redirect with an accepted pop in the same cycle.
    Redirect = 1'b1;
    RedirectTarget = 32'h43;
    step();
    Redirect = 1'b0;
    chk("rd_valid0", {31'd0, OutValid}, 32'd0);
    chk("rd_addr", Address, 32'h40);
    chk("rd_outpc0", OutPC, 32'h0);
    chk("rd_fcount", FetchCount, 32'd11);
    step();
    chk("rd_valid1", {31'd0, OutValid}, 32'd1);
    chk("rd_pc", OutPC, 32'h40);
    chk("rd_instr", OutInstruction, 32'd48);
    chk("rd_fcount1", FetchCount, 32'd11);
    step();
    chk("rd_pc_next", OutPC, 32'h44);
    chk("rd_fcount2", FetchCount, 32'd12);

    // Backpressure from reset.
    OutReady = 1'b0;
    do_reset();
    chk("bp_c0_addr", Address, 32'h0);
    step();
    chk("bp_c1_addr", Address, 32'h4);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("bp_addr_hold", Address, 32'h8);
      chk("bp_valid", {31'd0, OutValid}, 32'd1);
      chk("bp_pc", OutPC, 32'h0);
      chk("bp_instr", OutInstruction, 32'h0);
    end
    OutReady = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("bp_drain_valid", {31'd0, OutValid}, 32'd1);
      chk("bp_drain_pc", OutPC, 32'(4 * k));
    end
    chk("bp_fcount", FetchCount, 32'd3);

    // Full buffer with OutReady alternating, checked against a scoreboard.
    OutReady = 1'b0;
    do_reset();
    step();
    step();
    exp_pc = 32'h0;
    n_pops = 0;
    for (int i = 0; i < 16; i++) begin
      OutReady = (i % 2 == 0);
      chk("full_valid", {31'd0, OutValid}, 32'd1);
      chk("full_pc", OutPC, exp_pc);
      chk("full_instr", OutInstruction, (exp_pc >> 2) * 32'd3);
      chk("full_addr", Address, exp_pc + 32'd8);
      if (OutReady) begin
        exp_pc = exp_pc + 32'd4;
        n_pops++;
      end
      step();
    end
    chk("full_fcount", FetchCount, 32'(n_pops));
    chk("full_pc_end", OutPC, exp_pc);

    // Asynchronous reset between edges while data is valid.
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, OutValid}, 32'd0);
    chk("arst_pc", OutPC, 32'h0);
    chk("arst_fcount", FetchCount, 32'h0);
    chk("arst_addr", Address, 32'h0);
    step();
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-side initiator for the instruction memory. It owns the program counter, drives the word-aligned `Address` into the instruction memory, and captures the combinationally returned `Instruction` into a 2-entry buffer. It then hands `{PC, PC+4, instruction}` to decode with a valid/ready handshake and supports redirect (branch/jump) with full flush of buffered fetches.

## Interface

Parameters:

- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:

- `Clk` in 1: sole clock, rising-edge.
- `Reset` in 1: asynchronous, active-high.
- `Address` out 32: fetch address to instruction memory; always equals the PC register; bits [1:0] always 0.
- `Instruction` in 32: memory read data for `Address`, valid in the same cycle (combinational read).
- `Redirect` in 1: load a new PC and flush the buffer.
- `RedirectTarget` in 32: new PC; bits [1:0] ignored (forced to 0).
- `OutReady` in 1: decode accepts the head entry this cycle.
- `OutValid` out 1: head entry present.
- `OutInstruction` out 32: head instruction word.
- `OutPC` out 32: address the head word was fetched from.
- `OutPCPlus4` out 32: `OutPC` + 4, mod 2^32.
- `FetchCount` out 32: number of completed output transfers since reset; wraps at 2^32.

## Operation

- **State:**
  - PC register.
  - 2-entry FIFO of {pc, instr}, with head/tail pointers and a count of 0..2.
  - `FetchCount`.
- **Pop:** `pop = OutValid & OutReady`.
- **Push:** `push = ~Redirect & (count < 2 | pop)`.
  - A push writes {PC, `Instruction`} at the tail and sets PC <= PC + 4 (mod 2^32; 32'hFFFF_FFFC -> 0).
  - With no push, PC holds, so `Address` is stable under backpressure.
- **Count:** `count_next = count + push - pop`. At count=2, a simultaneous push and pop is legal and keeps count=2.
- **Output:** `OutValid = (count != 0)`. When `OutValid` = 0, `OutInstruction`, `OutPC` and `OutPCPlus4` are driven to 0.
- **Redirect** (dominates push):
  - PC <= {RedirectTarget[31:2], 2'b00}.
  - count <= 0 and both entries are discarded.
  - A pop occurring in the same cycle still completes and is counted in `FetchCount`.
- **FetchCount** increments by 1 on every pop.
- **Reset:** asynchronous. While asserted, and immediately on assertion with no clock edge needed:
  - PC = `RESET_PC`, so `Address` = `RESET_PC`.
  - count = 0, `OutValid` = 0.
  - `OutInstruction`, `OutPC`, `OutPCPlus4` = 0.
  - `FetchCount` = 0.
  - Buffer contents are don't-care.

## Timing

- **Reset-release latency:**
  - Cycle 0 after deassertion: `Address` = `RESET_PC`; push at the end of cycle 0.
  - `OutValid` = 1 in cycle 1.
- **Throughput:** 1 word/cycle with `OutReady` held at 1, with no bubbles.
- **Backpressure:**
  - With `OutReady` = 0, the buffer fills in 2 cycles and `Address` then freezes.
  - When `OutReady` rises, buffered words drain back-to-back and fetch resumes the same cycle. No bubble, no duplicate, no skipped word.
- **Redirect latency:**
  - `Redirect` sampled high at the end of cycle N.
  - Cycle N+1: `Address` = target, `OutValid` = 0.
  - Cycle N+2: `OutValid` = 1 with `OutPC` = target.
  - Repeated `Redirect` in consecutive cycles: the last one wins; `OutValid` stays 0 until 2 cycles after the final one.
- **Outputs** are registered-state functions, with no combinational path from `OutReady`/`Redirect` to `OutValid` or to the data outputs. `Address` depends only on the PC register.

## Test plan

- **Streaming:** memory[i] = i*3, reset, `OutReady` = 1.
  - Cycle 1 on: `OutPC` = 0, 4, 8, …; `OutInstruction` = 0, 3, 6, …; `OutPCPlus4` = 4, 8, 12, ….
  - After 10 transfers, `FetchCount` = 10.
- **Backpressure:** `OutReady` = 0 from reset.
  - `Address` = 0x8 from cycle 2 on, held; `OutPC` = 0, `OutInstruction` = 0.
  - Raise `OutReady`: `OutPC` sequence is 0, 4, 8, 0xC consecutive with `OutValid` continuously 1.
- **Redirect mid-stream:** `RedirectTarget` = 0x43, plus an accepted pop in the same cycle.
  - Next cycle: `OutValid` = 0, `Address` = 0x40.
  - Following cycle: `OutPC` = 0x40, `OutInstruction` = 48.
  - No pre-redirect word appears; `FetchCount` counts the same-cycle pop.
- **Simultaneous push/pop at full:** count=2, `OutReady` toggling 1/0/1.
  - Verify every address appears exactly once, in order, against a scoreboard.
- **Async reset mid-stream:** assert `Reset` between clock edges while `OutValid` = 1.
  - `OutValid`, `OutPC` and `FetchCount` go to 0 and `Address` = `RESET_PC` before the next edge.
- **Wrap:** `RESET_PC` = 32'hFFFF_FFFC.
  - `OutPC` = FFFF_FFFC then 0.
  - `OutPCPlus4` = 0 then 4.
